// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : buffered 8N1 UART transmitter with a small byte FIFO
// Revision: 1.0
// ============================================================================
module uart_tx #(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    output logic                          uart_txd,
    input  logic                          uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0]       uart_tx_data,
    input  logic                          uart_tx_valid,
    output logic                          uart_tx_ready,
    output logic                          uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   uart_tx_level
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int LVL_W          = PTR_W + 1;
    localparam int BITS_MAX       = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
    localparam int IDX_W          = $clog2(BITS_MAX) + 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] C_DATA_LAST = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [IDX_W-1:0] C_STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] C_DEPTH     = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [IDX_W-1:0]          r_idx;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [PAYLOAD_BITS-1:0]   r_shift;
    logic [PAYLOAD_BITS-1:0]   w_shift_nxt;

    logic [PAYLOAD_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [LVL_W-1:0]          r_level;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_has_data;
    logic                      w_bit_end;
    logic [PAYLOAD_BITS-1:0]   w_head;

    assign w_has_data    = (r_level != '0);
    assign w_bit_end     = (r_cnt == C_CNT_LAST);
    assign w_head        = r_mem[r_rd_ptr];
    assign uart_tx_ready = (r_level < C_DEPTH);
    assign w_push        = uart_tx_valid && uart_tx_ready;
    assign uart_tx_level = r_level;
    assign uart_tx_busy  = (r_state != S_IDLE) || w_has_data;

    // Line level decodes from registered state so reset drives it high at once.
    always_comb begin
        case (r_state)
            S_START: uart_txd = 1'b0;
            S_DATA:  uart_txd = r_shift[0];
            default: uart_txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= uart_tx_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (uart_tx_en && w_has_data) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_idx == C_DATA_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == C_STOP_LAST) begin
                        w_idx_nxt = '0;
                        // Chain straight into the next start bit when more data waits.
                        if (uart_tx_en && w_has_data) begin
                            w_pop       = 1'b1;
                            w_shift_nxt = w_head;
                            w_state_nxt = S_START;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
